// File: rtl/cpu_core_pkg.sv
// Shared constants and helpers for the reduced 4-bit CPU core harness.
package cpu_core_pkg;

    localparam logic [11:0] INC_X        = 12'hEE0;
    localparam logic [11:0] HALT         = 12'hFF8;
    localparam logic [3:0]  INT_PAGE     = 4'h1;
    localparam int          INSTR_STAGES = 5;
    localparam int          INT_STAGES   = 12;

    // Highest set request bit wins; bit n maps to vector n+1.
    function automatic logic [3:0] prio_vector(input logic [14:0] req);
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < 15; i++) begin
            if (req[i]) v = 4'(i + 1);
        end
        return v;
    endfunction

endpackage

// File: rtl/interrupt_sequencer.sv
// Instruction/interrupt sequencer: stage counter, HALT state, interrupt sampling
// and vector latch. Datapath and RAM live in the top.
module interrupt_sequencer
    import cpu_core_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [11:0] instr_i,
    input  logic        int_en_i,
    input  logic [14:0] req_i,
    output logic [3:0]  stage_o,
    output logic        perf_o,
    output logic        halted_o,
    output logic [3:0]  vec_o,
    output logic        instr_done_o,
    output logic        int_done_o
);

    localparam logic [1:0] ST_EXEC = 2'd0;
    localparam logic [1:0] ST_INT  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0] mode_q, mode_d;
    logic [3:0] stage_q, stage_d;
    logic [3:0] vec_q, vec_d;
    logic       take;

    assign take         = int_en_i && (|req_i);
    assign instr_done_o = (mode_q == ST_EXEC) && (stage_q == 4'(INSTR_STAGES - 1));
    assign int_done_o   = (mode_q == ST_INT) && (stage_q == 4'(INT_STAGES - 1));

    always_comb begin
        mode_d  = mode_q;
        stage_d = stage_q;
        vec_d   = vec_q;
        case (mode_q)
            ST_HALT: begin
                // The wake edge doubles as the sampling edge.
                if (take) begin
                    mode_d  = ST_INT;
                    stage_d = '0;
                    vec_d   = prio_vector(req_i);
                end
            end
            ST_INT: begin
                if (int_done_o) begin
                    mode_d  = ST_EXEC;
                    stage_d = '0;
                end else begin
                    stage_d = stage_q + 4'd1;
                end
            end
            default: begin
                if (instr_done_o) begin
                    stage_d = '0;
                    if (take) begin
                        mode_d = ST_INT;
                        vec_d  = prio_vector(req_i);
                    end else if (instr_i == HALT) begin
                        mode_d = ST_HALT;
                    end
                end else begin
                    stage_d = stage_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q  <= ST_EXEC;
            stage_q <= '0;
            vec_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            stage_q <= stage_d;
            vec_q   <= vec_d;
        end
    end

    assign stage_o  = stage_q;
    assign perf_o   = (mode_q == ST_INT);
    assign halted_o = (mode_q == ST_HALT);
    assign vec_o    = vec_q;

endmodule

// File: rtl/cpu_core_bench.sv
// Cycle-accurate harness: single-word ROM, architectural registers, 256x4 RAM
// and the interrupt push/vector datapath around the sequencer.
module cpu_core_bench
    import cpu_core_pkg::*;
#(
    parameter logic [11:0] INSTR    = 12'hEE0,
    parameter logic [12:0] RESET_PC = 13'h1234,
    parameter logic [11:0] RESET_X  = 12'h000,
    parameter logic [4:0]  RESET_NP = 5'h1F,
    parameter logic [7:0]  RESET_SP = 8'hFF,
    parameter logic        RESET_I  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [14:0] interrupt_req,
    output logic [12:0] pc,
    output logic [11:0] x,
    output logic [7:0]  sp,
    output logic [4:0]  np,
    output logic        interrupt_en,
    output logic        performing_interrupt,
    output logic [3:0]  stage,
    output logic        halted,
    output logic [7:0]  cycle_count,
    input  logic [7:0]  ram_addr,
    output logic [3:0]  ram_rdata
);

    logic [12:0] pc_q, pc_d;
    logic [11:0] x_q, x_d;
    logic [7:0]  sp_q, sp_d;
    logic [4:0]  np_q, np_d;
    logic        ie_q, ie_d;
    logic [7:0]  cyc_q;

    logic [3:0]  seq_stage, seq_vec;
    logic        seq_perf, seq_halted, instr_done, int_done;

    logic        push_en;
    logic [7:0]  push_addr;
    logic [3:0]  push_data;

    // Contents survive reset; only power-up zeroes them.
    logic [3:0]  ram_q [256] = '{default: 4'h0};

    interrupt_sequencer u_seq (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .instr_i      (INSTR),
        .int_en_i     (ie_q),
        .req_i        (interrupt_req),
        .stage_o      (seq_stage),
        .perf_o       (seq_perf),
        .halted_o     (seq_halted),
        .vec_o        (seq_vec),
        .instr_done_o (instr_done),
        .int_done_o   (int_done)
    );

    // Stages 1..3 push the return address high nibble first, growing down.
    always_comb begin
        push_en   = seq_perf && (seq_stage >= 4'd1) && (seq_stage <= 4'd3);
        push_addr = sp_q - {4'h0, seq_stage};
        case (seq_stage)
            4'd1:    push_data = pc_q[11:8];
            4'd2:    push_data = pc_q[7:4];
            default: push_data = pc_q[3:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_en) ram_q[push_addr] <= push_data;
    end

    always_comb begin
        pc_d = pc_q;
        x_d  = x_q;
        sp_d = sp_q;
        np_d = np_q;
        ie_d = ie_q;
        if (instr_done) begin
            pc_d = {pc_q[12:8], pc_q[7:0] + 8'd1};
            if (INSTR == INC_X) x_d = x_q + 12'd1;
        end
        if (seq_perf && seq_stage == 4'd3) begin
            sp_d = sp_q - 8'd3;
            ie_d = 1'b0;
        end
        if (int_done) begin
            pc_d = {pc_q[12], INT_PAGE, 4'h0, seq_vec};
            np_d = {pc_q[12], INT_PAGE};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RESET_PC;
            x_q   <= RESET_X;
            sp_q  <= RESET_SP;
            np_q  <= RESET_NP;
            ie_q  <= RESET_I;
            cyc_q <= '0;
        end else begin
            pc_q  <= pc_d;
            x_q   <= x_d;
            sp_q  <= sp_d;
            np_q  <= np_d;
            ie_q  <= ie_d;
            cyc_q <= cyc_q + 8'd1;
        end
    end

    assign pc                   = pc_q;
    assign x                    = x_q;
    assign sp                   = sp_q;
    assign np                   = np_q;
    assign interrupt_en         = ie_q;
    assign performing_interrupt = seq_perf;
    assign stage                = seq_stage;
    assign halted               = seq_halted;
    assign cycle_count          = cyc_q;
    assign ram_rdata            = ram_q[ram_addr];

endmodule

// File: tb/tb_cpu_core_bench.sv
// Directed + randomized checks of instruction timing, HALT and the interrupt sequence.
module tb_cpu_core_bench;

    logic        clk;
    logic        reset_n;
    logic [7:0]  ram_addr;
    logic [14:0] req   [4];
    logic [12:0] pc    [4];
    logic [11:0] x     [4];
    logic [7:0]  sp    [4];
    logic [4:0]  np    [4];
    logic        ie    [4];
    logic        perf  [4];
    logic [3:0]  stage [4];
    logic        hlt   [4];
    logic [7:0]  cyc   [4];
    logic [3:0]  rdat  [4];

    int ntot = 0;
    int npass = 0;
    int cnt = 0;

    // 0: INC X, 1: HALT, 2: INC X with I=0, 3: HALT with I=0
    for (genvar g = 0; g < 4; g++) begin : g_dut
        cpu_core_bench #(
            .INSTR   ((g % 2 == 1) ? 12'hFF8 : 12'hEE0),
            .RESET_I ((g < 2) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk                  (clk),
            .reset_n              (reset_n),
            .interrupt_req        (req[g]),
            .pc                   (pc[g]),
            .x                    (x[g]),
            .sp                   (sp[g]),
            .np                   (np[g]),
            .interrupt_en         (ie[g]),
            .performing_interrupt (perf[g]),
            .stage                (stage[g]),
            .halted               (hlt[g]),
            .cycle_count          (cyc[g]),
            .ram_addr             (ram_addr),
            .ram_rdata            (rdat[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ntot++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic step_to(input int t);
        while (cnt < t) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
    endtask

    task automatic rd(input int g, input logic [7:0] a, output logic [3:0] d);
        ram_addr = a;
        #1;
        d = rdat[g];
    endtask

    // Request raised c clocks after reset release; nv replaces it right after sampling.
    task automatic run_int(input int c, input int v, input int nv);
        int s, vec, ret;
        logic [3:0] d;
        s   = (c / 5 + 1) * 5;
        vec = $clog2(v + 1);
        ret = 'h1234 + s / 5;
        req[0] = '0;
        do_reset();
        step_to(c);
        req[0] = 15'(v);
        step_to(s);
        chk("samp_perf", 16'(perf[0]), 16'd1);
        chk("samp_x", 16'(x[0]), 16'(s / 5));
        chk("samp_pc", 16'(pc[0]), 16'(ret));
        req[0] = 15'(nv);
        step_to(s + 3);
        chk("ie_before_st3", 16'(ie[0]), 16'd1);
        step_to(s + 4);
        chk("ie_after_st3", 16'(ie[0]), 16'd0);
        chk("sp_after_st3", 16'(sp[0]), 16'hFC);
        step_to(s + 11);
        chk("last_stage_perf", 16'(perf[0]), 16'd1);
        chk("last_stage", 16'(stage[0]), 16'd11);
        step_to(s + 12);
        chk("done_perf", 16'(perf[0]), 16'd0);
        chk("done_pc", 16'(pc[0]), 16'('h1100 + vec));
        chk("done_np", 16'(np[0]), 16'h11);
        chk("done_cyc", 16'(cyc[0]), 16'(s + 12));
        rd(0, 8'hFE, d); chk("push_hi", 16'(d), 16'((ret >> 8) & 15));
        rd(0, 8'hFD, d); chk("push_mid", 16'(d), 16'((ret >> 4) & 15));
        rd(0, 8'hFC, d); chk("push_lo", 16'(d), 16'(ret & 15));
        step_to(s + 17);
        chk("isr_perf", 16'(perf[0]), 16'd0);
        chk("isr_x", 16'(x[0]), 16'(s / 5 + 1));
        chk("isr_pc", 16'(pc[0]), 16'('h1100 + vec + 1));
    endtask

    initial begin
        logic [3:0] d;
        int c, v, nv;
        reset_n  = 1'b1;
        ram_addr = 8'h00;
        req[0] = '0;
        req[1] = '0;
        req[2] = 15'h7FFF;
        req[3] = 15'h7FFF;

        // Reset values, sampled while reset is held
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_pc", 16'(pc[0]), 16'h1234);
        chk("rst_x", 16'(x[0]), 16'h000);
        chk("rst_sp", 16'(sp[0]), 16'hFF);
        chk("rst_np", 16'(np[0]), 16'h1F);
        chk("rst_ie", 16'(ie[0]), 16'd1);
        chk("rst_perf", 16'(perf[0]), 16'd0);
        chk("rst_stage", 16'(stage[0]), 16'd0);
        chk("rst_halted", 16'(hlt[1]), 16'd0);
        chk("rst_cyc", 16'(cyc[0]), 16'd0);
        rd(0, 8'hFE, d);
        chk("ram_init", 16'(d), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;

        // Interrupts disabled: 7FFF ignored, INC keeps running, HALT stays halted
        step_to(4);
        chk("dis_stage4", 16'(stage[2]), 16'd4);
        step_to(20);
        chk("dis_pc", 16'(pc[2]), 16'h1238);
        chk("dis_x", 16'(x[2]), 16'd4);
        chk("dis_perf", 16'(perf[2]), 16'd0);
        chk("dis_halt_h", 16'(hlt[3]), 16'd1);
        chk("dis_halt_pc", 16'(pc[3]), 16'h1235);
        chk("dis_halt_perf", 16'(perf[3]), 16'd0);

        // Directed interrupt cases: held through ISR, dropped early, raised in stage 4
        run_int(0, 'h0001, 'h0001);
        run_int(1, 'h0800, 'h0000);
        run_int(4, 'h4000, 'h0000);

        // Randomized request pattern, arrival time and post-sampling change
        for (int k = 0; k < 6; k++) begin
            c  = int'($urandom_range(0, 14));
            v  = int'($urandom_range(1, 32767));
            nv = int'($urandom_range(0, 32767));
            run_int(c, v, nv);
        end

        // HALT wake-up: 1 wake clock + 12-clock sequence
        req[1] = '0;
        do_reset();
        step_to(5);
        chk("halt_entry", 16'(hlt[1]), 16'd1);
        chk("halt_pc", 16'(pc[1]), 16'h1235);
        step_to(30);
        chk("halt_hold", 16'(hlt[1]), 16'd1);
        chk("halt_hold_pc", 16'(pc[1]), 16'h1235);
        req[1] = 15'h0040;
        step_to(31);
        chk("wake_halted", 16'(hlt[1]), 16'd0);
        chk("wake_perf", 16'(perf[1]), 16'd1);
        step_to(36);
        req[1] = '0;
        step_to(42);
        chk("wake_busy", 16'(perf[1]), 16'd1);
        step_to(43);
        chk("wake_done_perf", 16'(perf[1]), 16'd0);
        chk("wake_pc", 16'(pc[1]), 16'h1107);
        chk("wake_np", 16'(np[1]), 16'h11);
        chk("wake_sp", 16'(sp[1]), 16'hFC);
        rd(1, 8'hFE, d); chk("wake_push_hi", 16'(d), 16'h2);
        rd(1, 8'hFD, d); chk("wake_push_mid", 16'(d), 16'h3);
        rd(1, 8'hFC, d); chk("wake_push_lo", 16'(d), 16'h5);
        step_to(48);
        chk("isr_halt", 16'(hlt[1]), 16'd1);
        chk("isr_halt_pc", 16'(pc[1]), 16'h1108);

        // Reset in the middle of the sequence aborts it; RAM keeps pushed data
        req[0] = 15'h0001;
        do_reset();
        step_to(12);
        chk("mid_perf", 16'(perf[0]), 16'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_perf", 16'(perf[0]), 16'd0);
        chk("mid_rst_stage", 16'(stage[0]), 16'd0);
        chk("mid_rst_pc", 16'(pc[0]), 16'h1234);
        chk("mid_rst_sp", 16'(sp[0]), 16'hFF);
        chk("mid_rst_ie", 16'(ie[0]), 16'd1);
        chk("mid_rst_x", 16'(x[0]), 16'd0);
        rd(0, 8'hFE, d); chk("mid_rst_ram", 16'(d), 16'h2);
        reset_n = 1'b1;
        cnt = 0;
        req[0] = '0;
        step_to(5);
        chk("post_rst_pc", 16'(pc[0]), 16'h1235);
        chk("post_rst_perf", 16'(perf[0]), 16'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
